// File: rtl/bp_me_stream_mem_responder.sv
// BedRock stream memory responder: accepts a mem_cmd header plus streamed
// write beats, services it from a flop-array store and returns a streamed
// mem_resp with critical-beat-first wraparound inside the aligned transfer.

package bp_me_stream_mem_responder_pkg;

  localparam int unsigned paddr_width_gp   = 40;
  localparam int unsigned payload_width_gp = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_cce_mem_msg_header_s;

endpackage

module bp_me_stream_mem_responder
  import bp_me_stream_mem_responder_pkg::*;
#(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned block_width_p = 512,
  parameter int unsigned els_p         = 256
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  bp_bedrock_cce_mem_msg_header_s mem_cmd_header_i,
  input  logic [data_width_p-1:0]        mem_cmd_data_i,
  input  logic                           mem_cmd_v_i,
  output logic                           mem_cmd_ready_and_o,
  input  logic                           mem_cmd_last_i,

  output bp_bedrock_cce_mem_msg_header_s mem_resp_header_o,
  output logic [data_width_p-1:0]        mem_resp_data_o,
  output logic                           mem_resp_v_o,
  input  logic                           mem_resp_ready_and_i,
  output logic                           mem_resp_last_o
);

  localparam int unsigned lg_els_lp        = $clog2(els_p);
  localparam int unsigned beats_lp         = block_width_p / data_width_p;
  localparam int unsigned lg_beats_lp      = $clog2(beats_lp);
  localparam int unsigned data_bytes_lp    = data_width_p / 8;
  localparam int unsigned lg_data_bytes_lp = $clog2(data_bytes_lp);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_write = 2'd1,
    e_wresp = 2'd2,
    e_read  = 2'd3
  } state_e;

  state_e                         r_state, w_state_n;
  bp_bedrock_cce_mem_msg_header_s r_header;
  logic [lg_els_lp-1:0]           r_cnt;
  logic [data_width_p-1:0]        r_mem [els_p];

  logic                           w_cmd_ready, w_resp_v;
  logic                           w_cmd_hs, w_resp_hs;
  logic                           w_cmd_is_wr;
  logic                           w_rd_last;
  logic                           w_wr_en;
  logic [lg_els_lp-1:0]           w_wr_idx, w_rd_idx;
  logic [data_bytes_lp-1:0]       w_wr_be;
  logic [paddr_width_p-1:0]       w_wr_addr;
  bp_bedrock_msg_size_e           w_wr_size;
  logic [lg_els_lp-1:0]           w_wr_k;

  // Mask of the index bits that wrap within the aligned transfer (beats-1).
  function automatic logic [lg_els_lp-1:0] f_wrap_mask(input bp_bedrock_msg_size_e sz);
    int unsigned s, lg;
    s  = 32'(sz);
    lg = (s > lg_data_bytes_lp) ? (s - lg_data_bytes_lp) : 0;
    if (lg > lg_beats_lp) lg = lg_beats_lp;
    return lg_els_lp'((32'd1 << lg) - 32'd1);
  endfunction

  // Word touched by beat k: upper index bits fixed, low bits rotate by k.
  function automatic logic [lg_els_lp-1:0] f_beat_idx(input logic [paddr_width_p-1:0] addr,
                                                      input bp_bedrock_msg_size_e      sz,
                                                      input logic [lg_els_lp-1:0]      k);
    logic [lg_els_lp-1:0] base, m;
    base = addr[lg_data_bytes_lp +: lg_els_lp];
    m    = f_wrap_mask(sz);
    return (base & ~m) | ((base + k) & m);
  endfunction

  // Byte enables: full word for beat-sized or larger, else the addressed lanes.
  function automatic logic [data_bytes_lp-1:0] f_byte_en(input logic [paddr_width_p-1:0] addr,
                                                         input bp_bedrock_msg_size_e      sz);
    logic [data_bytes_lp-1:0] be;
    int unsigned s, off;
    s   = 32'(sz);
    off = 32'(addr[lg_data_bytes_lp-1:0]);
    for (int unsigned b = 0; b < data_bytes_lp; b++) begin
      be[b] = (s >= lg_data_bytes_lp) || ((b >= off) && (b < off + (32'd1 << s)));
    end
    return be;
  endfunction

  assign w_cmd_ready = (r_state == e_ready) || (r_state == e_write);
  assign w_resp_v    = (r_state == e_wresp) || (r_state == e_read);
  assign w_cmd_hs    = mem_cmd_v_i & w_cmd_ready;
  assign w_resp_hs   = w_resp_v & mem_resp_ready_and_i;
  assign w_cmd_is_wr = (mem_cmd_header_i.msg_type == e_bedrock_mem_wr) ||
                       (mem_cmd_header_i.msg_type == e_bedrock_mem_uc_wr);
  assign w_rd_last   = (r_cnt == f_wrap_mask(r_header.size));
  assign w_rd_idx    = f_beat_idx(r_header.addr, r_header.size, r_cnt);

  // Write beat address: first beat from the live header, later beats from the capture.
  always_comb begin
    w_wr_addr = r_header.addr;
    w_wr_size = r_header.size;
    w_wr_k    = r_cnt;
    if (r_state == e_ready) begin
      w_wr_addr = mem_cmd_header_i.addr;
      w_wr_size = mem_cmd_header_i.size;
      w_wr_k    = '0;
    end
  end

  assign w_wr_en  = !reset_i && w_cmd_hs &&
                    ((r_state == e_write) || ((r_state == e_ready) && w_cmd_is_wr));
  assign w_wr_idx = f_beat_idx(w_wr_addr, w_wr_size, w_wr_k);
  assign w_wr_be  = f_byte_en(w_wr_addr, w_wr_size);

  // Next-state logic for the single-message-in-flight protocol.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      e_ready: begin
        if (w_cmd_hs) begin
          if (!w_cmd_is_wr)       w_state_n = e_read;
          else if (mem_cmd_last_i) w_state_n = e_wresp;
          else                    w_state_n = e_write;
        end
      end
      e_write: if (w_cmd_hs && mem_cmd_last_i) w_state_n = e_wresp;
      e_wresp: if (w_resp_hs) w_state_n = e_ready;
      e_read:  if (w_resp_hs && w_rd_last) w_state_n = e_ready;
      default: w_state_n = e_ready;
    endcase
  end

  // State, captured header and beat counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= e_ready;
      r_header <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_n;
      if ((r_state == e_ready) && w_cmd_hs) begin
        r_header <= mem_cmd_header_i;
        r_cnt    <= w_cmd_is_wr ? lg_els_lp'(1) : '0;
      end else if (((r_state == e_write) && w_cmd_hs) || ((r_state == e_read) && w_resp_hs)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Backing store: byte-masked writes, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < data_bytes_lp; b++) begin
        if (w_wr_be[b]) r_mem[w_wr_idx][b*8 +: 8] <= mem_cmd_data_i[b*8 +: 8];
      end
    end
  end

  assign mem_cmd_ready_and_o = w_cmd_ready;
  assign mem_resp_v_o        = w_resp_v;
  assign mem_resp_header_o   = r_header;
  assign mem_resp_data_o     = (r_state == e_read) ? r_mem[w_rd_idx] : '0;
  assign mem_resp_last_o     = (r_state == e_wresp) || ((r_state == e_read) && w_rd_last);

endmodule
